// File: rtl/mem_port_arbiter.sv
// Two-master (fetch/data) to single memory port arbiter: grant in IDLE, m_req next cycle, response or timeout in WAIT.
// Arbitration is fixed data-first unless ARB_ROUND_ROBIN_EN is defined; no backpressure, requesters hold req until gnt.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_funct3,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [2:0]        m_funct3,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              err,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_q, owner_d;   // 1 = data port owns the transaction
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        funct3_q, funct3_d;

    logic              data_win;
    logic              gnt_vld;
    logic              rsp_vld;
    logic [DATA_W-1:0] rsp_dat;
    logic              err_c;

`ifdef ARB_ROUND_ROBIN_EN
    logic ptr_q, ptr_d;  // 1 = data side favoured on a tie

    assign data_win = d_req && (!i_req || ptr_q);
    assign ptr_d    = gnt_vld ? !data_win : ptr_q;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) ptr_q <= 1'b1;
        else          ptr_q <= ptr_d;
    end
`else
    assign data_win = d_req;
`endif

    assign gnt_vld = (state_q == ST_IDLE) && (i_req || d_req);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        rsp_vld  = 1'b0;
        rsp_dat  = '0;
        err_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    state_d = ST_ISSUE;
                    owner_d = data_win;
                    if (data_win) begin
                        we_d     = d_we;
                        addr_d   = d_addr;
                        wdata_d  = d_wdata;
                        funct3_d = d_funct3;
                    end else begin
                        we_d     = 1'b0;
                        addr_d   = i_addr;
                        wdata_d  = '0;
                        funct3_d = 3'b010;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A response in the final timeout cycle still wins over the error.
                if (m_rvalid) begin
                    rsp_vld = 1'b1;
                    rsp_dat = we_q ? '0 : m_rdata;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_vld = 1'b1;
                    err_c   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= 3'b000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
        end
    end

    // Grants are combinational, so reset gates them to keep every output low.
    assign d_gnt    = Reset_n && gnt_vld && data_win;
    assign i_gnt    = Reset_n && gnt_vld && !data_win;
    assign d_rvalid = rsp_vld && owner_q;
    assign i_rvalid = rsp_vld && !owner_q;
    assign d_rdata  = owner_q ? rsp_dat : '0;
    assign i_rdata  = owner_q ? '0 : rsp_dat;
    assign err      = err_c;
    assign busy     = (state_q != ST_IDLE);
    assign m_req    = (state_q == ST_ISSUE);
    assign m_we     = we_q;
    assign m_addr   = addr_q;
    assign m_wdata  = wdata_q;
    assign m_funct3 = funct3_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              CLK = 1'b0;
    logic              Reset_n;
    logic              i_req, d_req, d_we, m_rvalid;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [DATA_W-1:0] d_wdata, m_rdata;
    logic [2:0]        d_funct3;
    logic              i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we, err, busy;
    logic [DATA_W-1:0] i_rdata, d_rdata, m_wdata;
    logic [ADDR_W-1:0] m_addr;
    logic [2:0]        m_funct3;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(16)) dut (
        .CLK(CLK), .Reset_n(Reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_funct3(m_funct3),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .err(err), .busy(busy)
    );

    // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic clear_inputs();
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
        d_wdata = '0; d_funct3 = 3'b000; m_rvalid = 0; m_rdata = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        Reset_n = 0;
        i_req = 1; d_req = 1; m_rvalid = 1; m_rdata = 32'h1234_5678;
        #2;
        checks++;
        if ({i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, m_we, err, busy} !== 8'h00) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 00000000",
                     {i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, m_we, err, busy});
        end
        checks++;
        if ({m_addr, m_wdata, m_funct3, i_rdata, d_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_data: m_addr=%h m_wdata=%h m_funct3=%b i_rdata=%h d_rdata=%h expected all 0",
                     m_addr, m_wdata, m_funct3, i_rdata, d_rdata);
        end
        clear_inputs();
        tick();
        Reset_n = 1;
        tick();
    endtask

    task automatic test_single_fetch();
        tick();
        i_req = 1; i_addr = 32'h100;
        mid();
        checks++;
        if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL fetch_gnt: i_gnt=%b d_gnt=%b busy=%b expected 1 0 0", i_gnt, d_gnt, busy);
        end
        tick();
        i_req = 0;
        mid();
        checks++;
        if (m_req !== 1'b1 || m_addr !== 32'h100 || m_funct3 !== 3'b010 || m_we !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL fetch_issue: m_req=%b m_addr=%h m_funct3=%b m_we=%b busy=%b expected 1 100 010 0 1",
                     m_req, m_addr, m_funct3, m_we, busy);
        end
        tick();
        mid();
        checks++;
        if (m_req !== 1'b0 || i_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL fetch_wait: m_req=%b i_rvalid=%b expected 0 0", m_req, i_rvalid);
        end
        tick();
        m_rvalid = 1; m_rdata = 32'h0050_0093;
        mid();
        checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'h0050_0093 || d_rvalid !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL fetch_rsp: i_rvalid=%b i_rdata=%h d_rvalid=%b err=%b expected 1 00500093 0 0",
                     i_rvalid, i_rdata, d_rvalid, err);
        end
        tick();
        m_rvalid = 0; m_rdata = '0;
        mid();
        checks++;
        if (busy !== 1'b0 || i_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL fetch_done: busy=%b i_rvalid=%b expected 0 0", busy, i_rvalid);
        end
    endtask

    task automatic test_store_ack();
        tick();
        d_req = 1; d_we = 1; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF; d_funct3 = 3'b010;
        mid();
        checks++;
        if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin
            failures++;
            $display("FAIL store_gnt: d_gnt=%b i_gnt=%b expected 1 0", d_gnt, i_gnt);
        end
        tick();
        d_req = 0; d_we = 0; d_wdata = '0;
        mid();
        checks++;
        if (m_req !== 1'b1 || m_we !== 1'b1 || m_wdata !== 32'hDEAD_BEEF || m_addr !== 32'h2004 || m_funct3 !== 3'b010) begin
            failures++;
            $display("FAIL store_issue: m_req=%b m_we=%b m_wdata=%h m_addr=%h m_funct3=%b expected 1 1 deadbeef 2004 010",
                     m_req, m_we, m_wdata, m_addr, m_funct3);
        end
        tick();
        mid();
        checks++;
        if (m_we !== 1'b1 || m_wdata !== 32'hDEAD_BEEF || m_addr !== 32'h2004) begin
            failures++;
            $display("FAIL store_hold: m_we=%b m_wdata=%h m_addr=%h expected 1 deadbeef 2004", m_we, m_wdata, m_addr);
        end
        tick();
        m_rvalid = 1; m_rdata = 32'h1234_5678;
        mid();
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h0 || i_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL store_ack: d_rvalid=%b d_rdata=%h i_rvalid=%b expected 1 0 0", d_rvalid, d_rdata, i_rvalid);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_contention();
        logic exp_d;
        // Restart from reset so the round-robin pointer begins data-first.
        Reset_n = 0;
        tick();
        Reset_n = 1;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_d = (k % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            tick();
            m_rvalid = 0;
            i_req = 1; i_addr = 32'h300 + k; d_req = 1; d_we = 0; d_addr = 32'h400 + k; d_funct3 = 3'b010;
            mid();
            checks++;
            if (d_gnt !== exp_d || i_gnt !== !exp_d) begin
                failures++;
                $display("FAIL contention_gnt%0d: d_gnt=%b i_gnt=%b expected %b %b", k, d_gnt, i_gnt, exp_d, !exp_d);
            end
            tick();
            mid();
            checks++;
            if (i_gnt !== 1'b0 || d_gnt !== 1'b0 || m_addr !== (exp_d ? 32'h400 + k : 32'h300 + k)) begin
                failures++;
                $display("FAIL contention_issue%0d: i_gnt=%b d_gnt=%b m_addr=%h", k, i_gnt, d_gnt, m_addr);
            end
            tick();
            m_rvalid = 1; m_rdata = 32'hA000_0000 + k;
            mid();
            checks++;
            if (d_rvalid !== exp_d || i_rvalid !== !exp_d) begin
                failures++;
                $display("FAIL contention_rsp%0d: d_rvalid=%b i_rvalid=%b expected %b %b", k, d_rvalid, i_rvalid, exp_d, !exp_d);
            end
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_timeout();
        tick();
        d_req = 1; d_we = 0; d_addr = 32'h40; d_funct3 = 3'b100; m_rdata = 32'hFFFF_FFFF;
        mid();
        tick();
        d_req = 0;
        for (int w = 0; w < 15; w++) begin
            tick();
            mid();
            checks++;
            if (d_rvalid !== 1'b0 || err !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL timeout_early%0d: d_rvalid=%b err=%b busy=%b expected 0 0 1", w, d_rvalid, err, busy);
            end
        end
        tick();
        mid();
        checks++;
        if (d_rvalid !== 1'b1 || err !== 1'b1 || d_rdata !== 32'h0 || i_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL timeout_fire: d_rvalid=%b err=%b d_rdata=%h i_rvalid=%b expected 1 1 0 0",
                     d_rvalid, err, d_rdata, i_rvalid);
        end
        tick();
        i_req = 1; i_addr = 32'h200;
        mid();
        checks++;
        if (busy !== 1'b0 || err !== 1'b0 || i_gnt !== 1'b1) begin
            failures++;
            $display("FAIL timeout_idle: busy=%b err=%b i_gnt=%b expected 0 0 1", busy, err, i_gnt);
        end
        tick();
        i_req = 0;
        tick();
        m_rvalid = 1; m_rdata = 32'hCAFE_F00D;
        mid();
        checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'hCAFE_F00D || err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_recover: i_rvalid=%b i_rdata=%h err=%b expected 1 cafef00d 0", i_rvalid, i_rdata, err);
        end
        // Response arriving in the final timeout cycle beats the error.
        tick();
        m_rvalid = 0;
        d_req = 1; d_we = 0; d_addr = 32'h44; d_funct3 = 3'b010;
        tick();
        d_req = 0;
        for (int w = 0; w < 15; w++) tick();
        tick();
        m_rvalid = 1; m_rdata = 32'h0BAD_CAFE;
        mid();
        checks++;
        if (d_rvalid !== 1'b1 || err !== 1'b0 || d_rdata !== 32'h0BAD_CAFE) begin
            failures++;
            $display("FAIL timeout_race: d_rvalid=%b err=%b d_rdata=%h expected 1 0 0badcafe", d_rvalid, err, d_rdata);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid_wait();
        tick();
        d_req = 1; d_we = 0; d_addr = 32'h80; d_funct3 = 3'b010;
        tick();
        d_req = 0;
        tick();
        mid();
        checks++;
        if (busy !== 1'b1 || m_addr !== 32'h80) begin
            failures++;
            $display("FAIL rstwait_pending: busy=%b m_addr=%h expected 1 80", busy, m_addr);
        end
        tick();
        Reset_n = 0;
        #1;
        checks++;
        if ({busy, m_req, m_we, d_rvalid, i_rvalid, err, d_gnt, i_gnt} !== 8'h00 || m_addr !== '0 || m_funct3 !== 3'b000) begin
            failures++;
            $display("FAIL rstwait_async: ctrl=%b m_addr=%h m_funct3=%b expected 00000000 0 000",
                     {busy, m_req, m_we, d_rvalid, i_rvalid, err, d_gnt, i_gnt}, m_addr, m_funct3);
        end
        tick();
        Reset_n = 1;
        tick();
        m_rvalid = 1; m_rdata = 32'h5555_AAAA;
        mid();
        checks++;
        if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstwait_late: d_rvalid=%b i_rvalid=%b busy=%b expected 0 0 0", d_rvalid, i_rvalid, busy);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_spurious_rvalid();
        tick();
        m_rvalid = 1; m_rdata = 32'h7777_7777;
        mid();
        checks++;
        if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL spurious_rsp: i_rvalid=%b d_rvalid=%b busy=%b err=%b expected 0 0 0 0",
                     i_rvalid, d_rvalid, busy, err);
        end
        tick();
        m_rvalid = 0;
        mid();
        checks++;
        if (busy !== 1'b0 || m_req !== 1'b0) begin
            failures++;
            $display("FAIL spurious_idle: busy=%b m_req=%b expected 0 0", busy, m_req);
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store_ack();
        test_contention();
        test_timeout();
        test_reset_mid_wait();
        test_spurious_rvalid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning): ADDR_W, 32, address width; DATA_W, 32, data width; TIMEOUT, 16, maximum cycles to wait for a memory response.
REQ-002 SHALL have the ports below; clock and reset first (name direction width meaning). One clock; reset is asynchronous and active-low.
- CLK  in  1  single clock, rising edge
- Reset_n  in  1  asynchronous active-low reset
- i_req  in  1  instruction-fetch request, held until i_gnt
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch grant pulse
- i_rvalid  out  1  fetch response valid pulse
- i_rdata  out  DATA_W  fetch response data
- d_req  in  1  data request, held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_funct3  in  3  access size/sign code, forwarded unchanged
- d_gnt  out  1  data grant pulse
- d_rvalid  out  1  data response valid (load data or store ack)
- d_rdata  out  DATA_W  load data
- m_req  out  1  memory command strobe
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_funct3  out  3  memory size code (3'b010 for fetches)
- m_rvalid  in  1  memory response/ack strobe
- m_rdata  in  DATA_W  memory read data
- err  out  1  timeout error pulse, coincident with the owner's rvalid
- busy  out  1  high in every state except IDLE

Function
REQ-003 SHALL implement the FSM states IDLE, ISSUE and WAIT.
REQ-004 IDLE with any request SHALL select a winner combinationally and pulse that requester's gnt in the same cycle.
- The winner's command is registered into m_addr/m_we/m_wdata/m_funct3 and the owner register.
- Next state is ISSUE.
REQ-005 IDLE with no request SHALL stay in IDLE, with all gnt outputs 0.
REQ-006 ISSUE SHALL drive m_req=1 for exactly one cycle, then go to WAIT.
REQ-007 WAIT with m_rvalid=1 SHALL pulse the owner's rvalid in the same cycle.
- For a fetch or a load, the owner's rdata equals m_rdata; for a store, rdata is 0.
- Next state is IDLE.
REQ-008 Minimum latency SHALL be: request accepted at cycle N, m_req at N+1, earliest rvalid at N+2. Back-to-back grants occur no more often than every 3 cycles.
REQ-009 m_rvalid in IDLE or ISSUE SHALL be ignored: no rvalid is forwarded and there is no state change.
REQ-010 A wait counter SHALL clear on entry to WAIT and increment each cycle in WAIT.
- If the counter reaches TIMEOUT-1 without m_rvalid, the owner's rvalid=1, rdata=0 and err=1 for one cycle, and the FSM returns to IDLE.
- If m_rvalid arrives in that same cycle, the response wins and err=0.
REQ-011 m_* command outputs SHALL hold stable from ISSUE through WAIT. m_we is forced to 0 for fetches.
REQ-012 Only one gnt, and only one rvalid, SHALL be asserted in any cycle.

Reset
REQ-013 Reset_n=0 SHALL asynchronously force IDLE, with every output 0 and the wait counter 0.
- The owner register is cleared and the arbitration pointer is set to data-first.
REQ-014 Reset asserted mid-transaction SHALL abandon the transaction with no rvalid. A late m_rvalid after reset release is ignored under REQ-009.

Configuration
REQ-015 Macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
- Defined: round-robin. A one-bit pointer favours the requester not granted last; it updates on every grant; on simultaneous requests the favoured side wins.
- Undefined: fixed priority, data over fetch; the pointer logic is absent.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- Single fetch: i_req, i_addr=0x100; memory returns 0x00500093 after 2 cycles -> i_gnt at N, m_req at N+1 with m_addr=0x100, m_funct3=3'b010, m_we=0, i_rvalid with i_rdata=0x00500093 at N+3, busy low at N+4.
- Store ack: d_req, d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF, d_funct3=3'b010 -> m_we=1 and m_wdata=0xDEADBEEF; d_rvalid=1 and d_rdata=0 on ack; i_rvalid stays 0.
- Contention: i_req and d_req held high for 4 grants -> without the macro, all 4 go to data; with ARB_ROUND_ROBIN_EN, grants alternate D,I,D,I.
- Timeout: load issued and m_rvalid never returned -> after 16 WAIT cycles, d_rvalid=1, err=1, d_rdata=0, then IDLE; a following fetch completes normally.
- Reset mid-WAIT: Reset_n low for 1 cycle during a pending load -> all outputs 0 immediately; a late m_rvalid produces no d_rvalid.
- Spurious m_rvalid in IDLE -> no rvalid pulse and busy remains 0.
